// File: rtl/acc_core.sv
// acc_core: multi-cycle accumulator core with fetch/decode/execute FSM.
// Define ACC_CORE_SHIFT_EN to enable SHL/SHR (opcodes D/E); else NOPs.
module acc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int NREGS = 4,
  localparam int INSTR_W = 4 + DATA_W,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  output logic [ADDR_W-1:0]  prog_addr,
  output logic               prog_rd,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  acu,
  output logic [4:0]         flags,
  output logic [ADDR_W-1:0]  pc,
  output logic               retire,
  output logic               halted
);

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
`ifdef ACC_CORE_SHIFT_EN
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREGS];

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [REG_AW-1:0] n;
  logic [DATA_W-1:0] rn;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              cy_n;
  logic              ov_n;
  logic              acu_we;
  logic              flag_we;
  logic              reg_we;
  logic              jmp;
  logic [4:0]        flag_nx;
  logic [ADDR_W-1:0] pc_nx;

  assign op   = ir[INSTR_W-1 -: 4];
  assign imm  = ir[DATA_W-1:0];
  assign n    = imm[REG_AW-1:0];
  assign rn   = regs[n];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (run) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
      default:  state_nx = S_HALT;
    endcase
  end

  always_comb begin
    prog_rd   = (state == S_FETCH) && run;
    prog_addr = pc;
  end

  always_comb begin
    res     = acu;
    cy_n    = 1'b0;
    ov_n    = 1'b0;
    acu_we  = 1'b0;
    flag_we = 1'b0;
    reg_we  = 1'b0;
    jmp     = 1'b0;
    opnd    = (op == OP_ADDI) ? imm : rn;
    sum     = {1'b0, acu} + {1'b0, opnd};
    unique case (op)
      OP_LDI: begin
        res    = imm;
        acu_we = 1'b1;
      end
      OP_LD: begin
        res    = rn;
        acu_we = 1'b1;
      end
      OP_ST: reg_we = 1'b1;
      OP_ADD, OP_ADDI: begin
        res     = sum[DATA_W-1:0];
        cy_n    = sum[DATA_W];
        ov_n    = (acu[MSB] == opnd[MSB]) &&
                  (res[MSB] != acu[MSB]);
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUB: begin
        res     = acu - rn;
        cy_n    = acu < rn;
        ov_n    = (acu[MSB] != rn[MSB]) &&
                  (res[MSB] != acu[MSB]);
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin
        res     = acu & rn;
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        res     = acu | rn;
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        res     = acu ^ rn;
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_JMP: jmp = 1'b1;
      OP_JZ:  jmp = flags[0];
      OP_JC:  jmp = flags[1];
`ifdef ACC_CORE_SHIFT_EN
      OP_SHL: begin
        res     = {acu[MSB-1:0], 1'b0};
        cy_n    = acu[MSB];
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SHR: begin
        res     = {1'b0, acu[MSB:1]};
        cy_n    = acu[0];
        acu_we  = 1'b1;
        flag_we = 1'b1;
      end
`endif
      default: ;
    endcase
    flag_nx = {res[MSB], ~^res, ov_n, cy_n, res == '0};
    pc_nx   = jmp ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);
  end

  // HALT keeps pc on its own address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= '0;
      acu    <= '0;
      flags  <= '0;
      ir     <= '0;
      retire <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      retire <= (state == S_EXEC);
      if (state == S_DECODE) ir <= prog_data;
      if (state == S_EXEC) begin
        if (acu_we)  acu     <= res;
        if (flag_we) flags   <= flag_nx;
        if (reg_we)  regs[n] <= acu;
        if (op == OP_HALT) halted <= 1'b1;
        else               pc     <= pc_nx;
      end
    end
  end

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: directed programs checked against an instruction-level
// model stepped on every retire pulse, plus literal expectations.
module tb_acc_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  prog_addr;
  logic        prog_rd;
  logic [11:0] prog_data = '0;
  logic [7:0]  acu;
  logic [4:0]  flags;
  logic [4:0]  pc;
  logic        retire;
  logic        halted;

  acc_core #(.DATA_W(8), .ADDR_W(5), .NREGS(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .run(run),
    .prog_addr(prog_addr),
    .prog_rd(prog_rd),
    .prog_data(prog_data),
    .acu(acu),
    .flags(flags),
    .pc(pc),
    .retire(retire),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [32];

  always @(posedge clk) if (prog_rd) prog_data <= mem[prog_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ret_cnt = 0;
  int ret_cyc[$];

  int m_acu, m_pc;
  int m_r[4];
  bit m_s, m_p, m_ov, m_cy, m_z, m_halt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acu = 0; m_pc = 0; m_halt = 0;
    m_s = 0; m_p = 0; m_ov = 0; m_cy = 0; m_z = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    ret_cnt = 0;
    ret_cyc.delete();
  endtask

  task automatic model_step();
    int ins, op, imm, n, b, r, sa, sb, sr, npc;
    bit upd;
    ins = int'(mem[m_pc]);
    op  = ins >> 8;
    imm = ins & 255;
    n   = imm & 3;
    npc = (m_pc + 1) % 32;
    upd = 0;
    case (op)
      1: m_acu = imm;
      2: m_acu = m_r[n];
      3: m_r[n] = m_acu;
      4, 5, 9: begin
        b  = (op == 9) ? imm : m_r[n];
        sa = (m_acu > 127) ? m_acu - 256 : m_acu;
        sb = (b > 127) ? b - 256 : b;
        if (op == 5) begin
          r = m_acu - b; sr = sa - sb; m_cy = (m_acu < b);
        end else begin
          r = m_acu + b; sr = sa + sb; m_cy = (r > 255);
        end
        m_ov = (sr > 127) || (sr < -128);
        m_acu = r & 255;
        upd = 1;
      end
      6, 7, 8: begin
        if (op == 6) m_acu = m_acu & m_r[n];
        else if (op == 7) m_acu = m_acu | m_r[n];
        else m_acu = m_acu ^ m_r[n];
        m_cy = 0; m_ov = 0; upd = 1;
      end
      10: npc = imm % 32;
      11: if (m_z) npc = imm % 32;
      12: if (m_cy) npc = imm % 32;
`ifdef ACC_CORE_SHIFT_EN
      13: begin
        m_cy = (m_acu > 127); m_acu = (m_acu * 2) & 255;
        m_ov = 0; upd = 1;
      end
      14: begin
        m_cy = (m_acu % 2) == 1; m_acu = m_acu / 2;
        m_ov = 0; upd = 1;
      end
`endif
      15: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    if (upd) begin
      m_z = (m_acu == 0);
      m_s = (m_acu > 127);
      m_p = ($countones(m_acu) % 2) == 0;
    end
    m_pc = npc;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rstn) model_reset();
    else begin
      if (retire) begin
        model_step();
        ret_cnt++;
        ret_cyc.push_back(cyc);
      end
      chk("m_acu", acu, m_acu);
      chk("m_flags", flags, {m_s, m_p, m_ov, m_cy, m_z});
      chk("m_pc", pc, m_pc);
      chk("m_addr", prog_addr, m_pc);
      chk("m_halted", halted, m_halt);
      if (m_halt) chk("m_rd_halt", prog_rd, 0);
    end
  end

  task automatic do_reset();
    run = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
  endtask

  task automatic wait_ret(input int target, input string nm);
    int k;
    k = 0;
    while (ret_cnt < target && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (ret_cnt < target) begin
      failures++;
      $display("FAIL %s timeout retires=%0d required=%0d",
               nm, ret_cnt, target);
    end
  endtask

  initial begin
    clr_mem();
    do_reset();

    // idle with run low
    repeat (10) begin
      @(negedge clk); #1;
      chk("idle_rd", prog_rd, 0);
      chk("idle_pc", pc, 0);
      chk("idle_acu", acu, 0);
      chk("idle_flags", flags, 0);
      chk("idle_retire", retire, 0);
    end

    // arithmetic and flags
    do_reset();
    clr_mem();
    mem[0] = 12'h17F; mem[1] = 12'h301; mem[2] = 12'h901;
    mem[3] = 12'h501; mem[4] = 12'hF00;
    run = 1;
    wait_ret(3, "arith_addi");
    chk("addi_acu", acu, 8'h80);
    chk("addi_flags", flags, 5'b10100);
    wait_ret(4, "arith_sub");
    chk("sub_acu", acu, 8'h01);
    chk("sub_flags", flags, 5'b00100);
    wait_ret(5, "arith_halt");
    chk("arith_halted", halted, 1);

    // carry/zero branch
    do_reset();
    clr_mem();
    mem[0] = 12'h1FF; mem[1] = 12'h901; mem[2] = 12'hB10;
    mem[16] = 12'hF00;
    run = 1;
    wait_ret(3, "br_jz");
    chk("br_acu", acu, 8'h00);
    chk("br_flags", flags, 5'b01011);
    chk("br_addr", prog_addr, 5'h10);
    chk("br_count", ret_cnt, 3);
    chk("br_gap1", ret_cyc[1] - ret_cyc[0], 3);
    chk("br_gap2", ret_cyc[2] - ret_cyc[1], 3);
    wait_ret(4, "br_halt");

    // wrap and halt at address 0
    do_reset();
    clr_mem();
    mem[0] = 12'hA1F; mem[31] = 12'h000;
    run = 1;
    wait_ret(1, "wrap_jmp");
    chk("wrap_jmp_pc", pc, 5'h1F);
    mem[0] = 12'hF00;
    wait_ret(2, "wrap_nop");
    chk("wrap_pc", pc, 0);
    wait_ret(3, "wrap_halt");
    chk("wrap_halted", halted, 1);
    repeat (6) begin
      @(negedge clk); #1;
      chk("halt_rd", prog_rd, 0);
      chk("halt_pc", pc, 0);
      chk("halt_retire", retire, 0);
    end

    // run gating and reset during EXEC
    do_reset();
    clr_mem();
    mem[0] = 12'h133; mem[1] = 12'h155;
    run = 1;
    @(posedge clk); #1;
    run = 0;
    chk("gate_rd_decode", prog_rd, 0);
    wait_ret(1, "gate_ret");
    chk("gate_acu", acu, 8'h33);
    repeat (6) begin
      @(negedge clk); #1;
      chk("gate_rd", prog_rd, 0);
      chk("gate_pc", pc, 1);
      chk("gate_count", ret_cnt, 1);
    end
    run = 1;
    @(posedge clk); #1;
    run = 0;
    @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("rst_acu", acu, 0);
    chk("rst_pc", pc, 0);
    @(posedge clk); #1;
    chk("rst_acu_hold", acu, 0);
    chk("rst_retire", retire, 0);
    rstn = 1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_after_acu", acu, 0);
      chk("rst_after_pc", pc, 0);
    end

    // shift opcodes
    do_reset();
    clr_mem();
    mem[0] = 12'h181; mem[1] = 12'hD00; mem[2] = 12'hE00;
    mem[3] = 12'hF00;
    run = 1;
    wait_ret(2, "shl");
`ifdef ACC_CORE_SHIFT_EN
    chk("shl_acu", acu, 8'h02);
    chk("shl_flags", flags, 5'b00010);
`else
    chk("shl_acu", acu, 8'h81);
    chk("shl_flags", flags, 5'b00000);
`endif
    chk("shl_pc", pc, 2);
    wait_ret(4, "shift_halt");

    // logic ops, LD/ST, carry branch
    do_reset();
    clr_mem();
    mem[0] = 12'h1F0; mem[1] = 12'h302; mem[2] = 12'h13C;
    mem[3] = 12'h602; mem[4] = 12'h702; mem[5] = 12'h802;
    mem[6] = 12'h202; mem[7] = 12'h402; mem[8] = 12'hC0C;
    mem[12] = 12'h502; mem[13] = 12'hF00;
    run = 1;
    wait_ret(6, "logic_xor");
    chk("xor_acu", acu, 8'h00);
    chk("xor_flags", flags, 5'b01001);
    wait_ret(8, "logic_add");
    chk("add_acu", acu, 8'hE0);
    chk("add_flags", flags, 5'b10010);
    wait_ret(9, "logic_jc");
    chk("jc_pc", pc, 5'h0C);
    wait_ret(11, "logic_halt");
    chk("logic_halted", halted, 1);

    run = 0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
